// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
// One transaction in flight; data has priority, a loss counter bounds fetch starvation.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_STALL = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

  logic [1:0] state;
  logic       owner;
  logic [3:0] stall_cnt;
  logic       fetch_wins;

  // Fetch wins alone, or when it has already lost MAX_STALL contested rounds.
  assign fetch_wins = bus.if_req && (!bus.d_req || stall_cnt == STALL_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      stall_cnt     <= 4'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state       <= REQ;
            bus.mem_req <= 1'b1;
            if (fetch_wins) begin
              owner         <= OWN_IF;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= '0;
              bus.mem_be    <= '1;
              stall_cnt     <= 4'd0;
            end else begin
              owner         <= OWN_D;
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_be    <= bus.d_be;
              if (bus.if_req) begin
                stall_cnt <= stall_cnt + 4'd1;
              end
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            state       <= RESP;
            bus.mem_req <= 1'b0;
          end
        end
        RESP: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = bus.mem_gnt    && (state == REQ)  && (owner == OWN_IF);
  assign bus.d_gnt     = bus.mem_gnt    && (state == REQ)  && (owner == OWN_D);
  assign bus.if_rvalid = bus.mem_rvalid && (state == RESP) && (owner == OWN_IF);
  assign bus.d_rvalid  = bus.mem_rvalid && (state == RESP) && (owner == OWN_D);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table, corner sequences and random run against a transaction model
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_STALL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        ir;
    logic        dr;
    logic        dwe;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic        exp_d;
    logic        exp_we;
    logic [31:0] exp_a;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Plays the memory for one transaction: waits for mem_req, withholds gnt gd cycles,
  // answers rd cycles after gnt, and checks handshake/response routing along the way.
  task automatic serve(input int gd, input int rd, input logic [31:0] rdata,
                       output logic got_d, output int wait_n, output logic [31:0] a,
                       output logic we, output logic [31:0] wd, output logic [3:0] be);
    got_d = 0; a = 0; we = 0; wd = 0; be = 0; wait_n = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    #1;
    while (!bus.mem_req && wait_n < 10) begin
      @(negedge clk); #1;
      wait_n++;
    end
    check("mem_req_seen", bus.mem_req, 1);
    if (bus.mem_req) begin
      a = bus.mem_addr; we = bus.mem_we; wd = bus.mem_wdata; be = bus.mem_be;
      for (int i = 0; i < gd; i++) begin
        check("stall_req", bus.mem_req, 1);
        check("stall_addr", bus.mem_addr, a);
        check("stall_wdata", bus.mem_wdata, wd);
        check("stall_be", bus.mem_be, be);
        check("stall_no_gnt", {bus.if_gnt, bus.d_gnt}, 0);
        @(negedge clk); #1;
      end
      bus.mem_gnt = 1; #1;
      check("gnt_addr", bus.mem_addr, a);
      check("gnt_onehot", bus.if_gnt ^ bus.d_gnt, 1);
      got_d = bus.d_gnt;
      @(negedge clk);
      bus.mem_gnt = 0; #1;
      check("req_drop", bus.mem_req, 0);
      for (int i = 0; i < rd; i++) begin
        check("early_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
        @(negedge clk); #1;
      end
      bus.mem_rvalid = 1; bus.mem_rdata = rdata; #1;
      check("own_rvalid", got_d ? bus.d_rvalid : bus.if_rvalid, 1);
      check("other_rvalid", got_d ? bus.if_rvalid : bus.d_rvalid, 0);
      check("rdata", got_d ? bus.d_rdata : bus.if_rdata, rdata);
      @(negedge clk);
      bus.mem_rvalid = 0; #1;
    end
  endtask

  logic        got_d, we, cur_d, cur_we, ifp, dp, dwe;
  logic [31:0] a, wd, cur_a, cur_wd, ia, da, dwd;
  logic [3:0]  be, cur_be, dbe;
  int          wn, losses, rwait;
  bit          busy, granted;

  initial begin
    rst = 1;
    idle_inputs();
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0,        4'h0,    32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 32'h100, 4'hF};
    vt[1] = '{1'b1, 1'b1, 1'b1, 32'h300, 32'h200, 32'h12345678, 4'b0011, 32'h0,        0, 0, 1'b1, 1'b1, 32'h200, 4'b0011};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h44,  32'h0,        4'hC,    32'hCAFEF00D, 0, 0, 1'b1, 1'b0, 32'h44,  4'hC};
    vt[3] = '{1'b1, 1'b0, 1'b0, 32'hFFC, 32'h0,   32'h0,        4'h0,    32'h01020304, 3, 1, 1'b0, 1'b0, 32'hFFC, 4'hF};
    vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h88,  32'hA5A5A5A5, 4'b1000, 32'h0,        1, 2, 1'b1, 1'b1, 32'h88,  4'b1000};
    vt[5] = '{1'b1, 1'b1, 1'b0, 32'h10,  32'h20,  32'h0,        4'hF,    32'h55AA55AA, 0, 0, 1'b1, 1'b0, 32'h20,  4'hF};

    // Reset with every input active, including a stray response
    bus.if_req = 1; bus.d_req = 1; bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hA5A50F0F;
    @(negedge clk); @(negedge clk); #1;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_gnt", {bus.if_gnt, bus.d_gnt}, 0);
    check("rst_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
    check("rst_mem_fields", {bus.mem_we, bus.mem_addr, bus.mem_be}, 0);
    check("rst_if_rdata", bus.if_rdata, 32'hA5A50F0F);
    check("rst_d_rdata", bus.d_rdata, 32'hA5A50F0F);
    idle_inputs();
    rst = 0;

    foreach (vt[i]) begin
      do_reset();
      bus.if_req = vt[i].ir; bus.if_addr = vt[i].ia;
      bus.d_req = vt[i].dr; bus.d_we = vt[i].dwe; bus.d_addr = vt[i].da;
      bus.d_wdata = vt[i].dwd; bus.d_be = vt[i].dbe;
      serve(vt[i].gd, vt[i].rd, vt[i].rdata, got_d, wn, a, we, wd, be);
      bus.if_req = 0; bus.d_req = 0;
      check($sformatf("v%0d_owner", i), got_d, vt[i].exp_d);
      check($sformatf("v%0d_latency", i), wn, 1);
      check($sformatf("v%0d_addr", i), a, vt[i].exp_a);
      check($sformatf("v%0d_we", i), we, vt[i].exp_we);
      check($sformatf("v%0d_be", i), be, vt[i].exp_be);
      if (vt[i].exp_d) check($sformatf("v%0d_wdata", i), wd, vt[i].dwd);
    end

    // Contested store, then the waiting fetch goes out right after the response
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h300;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
    serve(0, 0, 32'h0, got_d, wn, a, we, wd, be);
    bus.d_req = 0;
    check("sim_first_data", got_d, 1);
    serve(0, 0, 32'h77, got_d, wn, a, we, wd, be);
    bus.if_req = 0;
    check("sim_then_fetch", got_d, 0);
    check("sim_fetch_latency", wn, 1);
    check("sim_fetch_addr", a, 32'h300);

    // Continuous contention: 4 data wins then one fetch, repeating
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800; bus.d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      serve(0, 0, 32'(k), got_d, wn, a, we, wd, be);
      check($sformatf("starve_%0d", k), got_d, (k % 5) != 4);
    end
    idle_inputs();

    // Asynchronous reset while mem_req is up drops it without a clock edge
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h123;
    @(negedge clk); #1;
    check("areq_up", bus.mem_req, 1);
    #2 rst = 1;
    #1 check("areq_async_drop", bus.mem_req, 0);
    idle_inputs();
    @(negedge clk);
    rst = 0;

    // Reset while waiting for a response after building up fetch losses
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h500;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h600; bus.d_wdata = 32'h9; bus.d_be = 4'hF;
    for (int k = 0; k < 3; k++) serve(0, 0, 32'h0, got_d, wn, a, we, wd, be);
    @(negedge clk); #1;
    check("rr_req", bus.mem_req, 1);
    bus.mem_gnt = 1; #1;
    check("rr_dgnt", bus.d_gnt, 1);
    @(negedge clk);
    bus.mem_gnt = 0;
    #1 rst = 1;
    bus.if_req = 0; bus.d_req = 0;
    @(negedge clk);
    rst = 0;
    bus.mem_rvalid = 1; #1;
    check("rr_late_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
    @(negedge clk);
    bus.mem_rvalid = 0;
    bus.if_req = 1; bus.d_req = 1;
    for (int k = 0; k < 5; k++) begin
      serve(0, 0, 32'h0, got_d, wn, a, we, wd, be);
      check($sformatf("rr_after_%0d", k), got_d, k != 4);
    end

    // Random traffic against a transaction-level model
    do_reset();
    ifp = 0; dp = 0; busy = 0; granted = 0; losses = 0; rwait = 0;
    ia = 0; da = 0; dwd = 0; dwe = 0; dbe = 0;
    cur_d = 0; cur_a = 0; cur_wd = 0; cur_we = 0; cur_be = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!ifp && $urandom_range(2) == 0) begin ifp = 1; ia = $urandom; end
      if (!dp && $urandom_range(2) == 0) begin
        dp = 1; da = $urandom; dwd = $urandom; dwe = 1'($urandom_range(1)); dbe = 4'($urandom);
      end
      bus.if_req = ifp; bus.if_addr = ia;
      bus.d_req = dp; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd; bus.d_be = dbe;
      bus.mem_gnt = 1'($urandom_range(1));
      bus.mem_rdata = $urandom;
      if (busy && granted) bus.mem_rvalid = (rwait == 0);
      else bus.mem_rvalid = ($urandom_range(3) == 0);
      #1;
      check("rnd_mem_req", bus.mem_req, busy && !granted);
      if (busy) begin
        check("rnd_addr", bus.mem_addr, cur_a);
        check("rnd_we", bus.mem_we, cur_we);
        check("rnd_be", bus.mem_be, cur_be);
        if (cur_d) check("rnd_wdata", bus.mem_wdata, cur_wd);
      end
      check("rnd_if_gnt", bus.if_gnt, bus.mem_gnt && busy && !granted && !cur_d);
      check("rnd_d_gnt", bus.d_gnt, bus.mem_gnt && busy && !granted && cur_d);
      check("rnd_if_rvalid", bus.if_rvalid, bus.mem_rvalid && busy && granted && !cur_d);
      check("rnd_d_rvalid", bus.d_rvalid, bus.mem_rvalid && busy && granted && cur_d);
      if (bus.mem_rvalid && busy && granted)
        check("rnd_rdata", cur_d ? bus.d_rdata : bus.if_rdata, bus.mem_rdata);
      if (!busy) begin
        if (ifp || dp) begin
          if (ifp && (!dp || losses == MAX_STALL)) begin
            cur_d = 0; cur_a = ia; cur_we = 0; cur_be = 4'hF; losses = 0;
          end else begin
            cur_d = 1; cur_a = da; cur_we = dwe; cur_wd = dwd; cur_be = dbe;
            if (ifp) losses++;
          end
          busy = 1; granted = 0;
        end
      end else if (!granted) begin
        if (bus.mem_gnt) begin
          granted = 1;
          rwait = $urandom_range(2);
          if (cur_d) dp = 0; else ifp = 0;
        end
      end else if (rwait == 0) begin
        busy = 0;
      end else begin
        rwait--;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of cpu_top between the instruction-fetch unit and the load/store unit.
- Arbitrates requests and allows one outstanding transaction at a time.
- Latches the winner's request and drives the memory-side req/gnt handshake.
- Routes the memory response back to the owning requester.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
- AW, 32, address width
- DW, 32, data width; DW/8 byte enables
- MAX_STALL, 4, consecutive fetch losses before fetch is forced to win (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted by memory
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetch data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data valid / store acknowledge
- d_rdata  out  DW  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  DW/8  memory byte enables
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response valid; exactly one per accepted request, reads and writes
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset:
  - rst=1 asynchronously forces state=IDLE, owner=IF, stall_cnt=0.
  - All mem_* registered outputs go to 0.
  - All *_gnt and *_rvalid go to 0.
  - if_rdata and d_rdata are pass-throughs of mem_rdata.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any request is pending, choose a winner.
  - Latch the winner's fields into mem_addr/mem_we/mem_wdata/mem_be.
  - Set owner and go to REQ; mem_req=1 from the next cycle.
  - For a fetch, mem_we=0 and mem_be is all-ones.
- Arbitration in IDLE:
  - Only d_req: data wins.
  - Only if_req: fetch wins; stall_cnt<=0.
  - Both, and stall_cnt<MAX_STALL: data wins; stall_cnt++.
  - Both, and stall_cnt==MAX_STALL: fetch wins; stall_cnt<=0.
  - Neither: stay in IDLE; stall_cnt unchanged.
- REQ:
  - mem_req=1; mem_* fields held stable until mem_gnt.
  - On the mem_gnt cycle, pulse owner's gnt combinationally (if_gnt = mem_gnt & state==REQ & owner==IF; d_gnt likewise).
  - Next state RESP; mem_req<=0.
- RESP:
  - Owner's rvalid = mem_rvalid & state==RESP & owner match, combinational.
  - rdata is passed through.
  - The non-owner's rvalid stays 0.
  - On mem_rvalid, next state IDLE.
- Latency and throughput:
  - Minimum: request sampled in IDLE at cycle N; mem_req at N+1; gnt at N+1 if mem_gnt; rvalid at N+2 if memory responds next cycle; IDLE at N+3.
  - Peak throughput is one transaction per 3 cycles.
- Request sampling: requests are sampled only in IDLE. A requester that withdraws before its gnt is a protocol violation; the latched transaction still completes and gnt still pulses.
- Stray responses: mem_rvalid in IDLE or REQ is ignored; no rvalid to either requester.
- mem_gnt outside REQ is ignored.
- Reset mid-transaction: abandon the transaction, return to IDLE, and drop mem_req immediately (asynchronous). A late mem_rvalid after reset is ignored.
- stall_cnt is 4 bits and cannot exceed MAX_STALL.

Test Plan:
- Reset: rst pulse with mem_rvalid=1 -> mem_req=0, if_gnt=d_gnt=0, if_rvalid=d_rvalid=0; state IDLE.
- Single fetch: if_req=1, if_addr=0x100; mem_gnt=1 on the first mem_req cycle; mem_rvalid one cycle later with rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, mem_be=4'hF, if_gnt pulse, if_rvalid=1 with 0xDEADBEEF; d_rvalid stays 0.
- Simultaneous requests: if_req and d_req (store, addr 0x200, wdata 0x12345678, be 4'b0011) together -> data transaction issued first with mem_we=1 and those fields; fetch issued immediately after the data response.
- Starvation: MAX_STALL=4, d_req and if_req held continuously with immediate gnt/response -> exactly 4 data grants, then 1 fetch grant, pattern repeats; if_gnt never delayed beyond 4 data transactions.
- Stalled memory: mem_gnt held low 3 cycles -> mem_req=1 and mem_addr/mem_wdata/mem_be unchanged for 4 cycles; gnt pulses only in the mem_gnt cycle.
- Reset in RESP: assert rst while waiting for the response, release, then inject mem_rvalid=1 -> no if_rvalid/d_rvalid; next new request arbitrated normally with stall_cnt=0.
